// File: rtl/scalar_io_handshake_bank.sv
`default_nettype none
// ============================================================================
// Module      : scalar_io_handshake_bank
// Description : Per-port FIFO buffering and valid/ready handshakes for one
//               scalar-core I/O memory, with an all-or-nothing io_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module scalar_io_handshake_bank #(
    parameter int WORD_WIDTH        = 36,
    parameter int READ_PORT_COUNT   = 4,
    parameter int WRITE_PORT_COUNT  = 4,
    parameter int FIFO_DEPTH        = 2,
    parameter int FIFO_ADDR_WIDTH   = 1,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [READ_PORT_COUNT-1:0]             core_rden,
    output logic [WORD_WIDTH*READ_PORT_COUNT-1:0]  core_read_data,
    input  logic [WRITE_PORT_COUNT-1:0]            core_wren,
    input  logic [WORD_WIDTH*WRITE_PORT_COUNT-1:0] core_write_data,
    output logic                                   io_ready,
    input  logic [READ_PORT_COUNT-1:0]             in_valid,
    input  logic [WORD_WIDTH*READ_PORT_COUNT-1:0]  in_data,
    output logic [READ_PORT_COUNT-1:0]             in_ready,
    output logic [WRITE_PORT_COUNT-1:0]            out_valid,
    output logic [WORD_WIDTH*WRITE_PORT_COUNT-1:0] out_data,
    input  logic [WRITE_PORT_COUNT-1:0]            out_ready,
    output logic [STALL_COUNT_WIDTH-1:0]           stall_count
);

    localparam int                           c_cnt_w     = FIFO_ADDR_WIDTH + 1;
    localparam logic [c_cnt_w-1:0]           c_full      = c_cnt_w'(FIFO_DEPTH);
    localparam logic [STALL_COUNT_WIDTH-1:0] c_stall_max = '1;

    logic [READ_PORT_COUNT-1:0]  w_rd_ok;
    logic [WRITE_PORT_COUNT-1:0] w_wr_ok;
    logic                        w_io_ready;
    logic                        w_any_req;

    assign w_io_ready = (&w_rd_ok) & (&w_wr_ok);
    assign io_ready   = w_io_ready;
    assign w_any_req  = (|core_rden) | (|core_wren);

    genvar gi;
    genvar gj;

    // Read ports: external producer fills, core pops into a held output register.
    generate
        for (gi = 0; gi < READ_PORT_COUNT; gi++) begin : g_rd_port
            logic [WORD_WIDTH-1:0]      r_mem [FIFO_DEPTH];
            logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
            logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
            logic [c_cnt_w-1:0]         r_count;
            logic [c_cnt_w-1:0]         w_count_next;
            logic [WORD_WIDTH-1:0]      r_data;
            logic                       r_in_ready;
            logic                       w_push;
            logic                       w_pop;

            assign w_push       = in_valid[gi] & r_in_ready;
            assign w_pop        = core_rden[gi] & w_io_ready;
            assign w_rd_ok[gi]  = ~core_rden[gi] | (r_count != '0);

            always_comb begin
                w_count_next = r_count;
                case ({w_push, w_pop})
                    2'b10:   w_count_next = r_count + 1'b1;
                    2'b01:   w_count_next = r_count - 1'b1;
                    default: w_count_next = r_count;
                endcase
            end

            // in_ready follows the post-edge occupancy, so a full FIFO refuses
            // external data even in the cycle it is being popped.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_wr_ptr   <= '0;
                    r_rd_ptr   <= '0;
                    r_count    <= '0;
                    r_data     <= '0;
                    r_in_ready <= 1'b0;
                    for (int k = 0; k < FIFO_DEPTH; k++) begin
                        r_mem[k] <= '0;
                    end
                end else begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= in_data[gi*WORD_WIDTH +: WORD_WIDTH];
                        r_wr_ptr        <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_data   <= r_mem[r_rd_ptr];
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    r_count    <= w_count_next;
                    r_in_ready <= (w_count_next != c_full);
                end
            end

            assign in_ready[gi]                                = r_in_ready;
            assign core_read_data[gi*WORD_WIDTH +: WORD_WIDTH] = r_data;
        end
    endgenerate

    // Write ports: core pushes, external consumer drains the head.
    generate
        for (gj = 0; gj < WRITE_PORT_COUNT; gj++) begin : g_wr_port
            logic [WORD_WIDTH-1:0]      r_mem [FIFO_DEPTH];
            logic [FIFO_ADDR_WIDTH-1:0] r_wr_ptr;
            logic [FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
            logic [c_cnt_w-1:0]         r_count;
            logic [c_cnt_w-1:0]         w_count_next;
            logic                       r_out_valid;
            logic                       w_push;
            logic                       w_pop;

            assign w_pop  = r_out_valid & out_ready[gj];
            assign w_push = core_wren[gj] & w_io_ready;
            // A full FIFO still accepts a core push when the head drains this edge.
            assign w_wr_ok[gj] = ~core_wren[gj] | (r_count != c_full) | w_pop;

            always_comb begin
                w_count_next = r_count;
                case ({w_push, w_pop})
                    2'b10:   w_count_next = r_count + 1'b1;
                    2'b01:   w_count_next = r_count - 1'b1;
                    default: w_count_next = r_count;
                endcase
            end

            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    r_wr_ptr    <= '0;
                    r_rd_ptr    <= '0;
                    r_count     <= '0;
                    r_out_valid <= 1'b0;
                    for (int k = 0; k < FIFO_DEPTH; k++) begin
                        r_mem[k] <= '0;
                    end
                end else begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= core_write_data[gj*WORD_WIDTH +: WORD_WIDTH];
                        r_wr_ptr        <= r_wr_ptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                    r_count     <= w_count_next;
                    r_out_valid <= (w_count_next != '0);
                end
            end

            assign out_valid[gj]                         = r_out_valid;
            assign out_data[gj*WORD_WIDTH +: WORD_WIDTH] = r_out_valid ? r_mem[r_rd_ptr] : '0;
        end
    endgenerate

    logic [STALL_COUNT_WIDTH-1:0] r_stall_count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_stall_count <= '0;
        end else if (w_any_req && !w_io_ready && (r_stall_count != c_stall_max)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_scalar_io_handshake_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_scalar_io_handshake_bank
// Description : Scoreboard bench for scalar_io_handshake_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_io_handshake_bank;

    localparam int W  = 36;
    localparam int NR = 4;
    localparam int NW = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic [NR-1:0]   core_rden;
    logic [W*NR-1:0] core_read_data;
    logic [NW-1:0]   core_wren;
    logic [W*NW-1:0] core_write_data;
    logic            io_ready;
    logic [NR-1:0]   in_valid;
    logic [W*NR-1:0] in_data;
    logic [NR-1:0]   in_ready;
    logic [NW-1:0]   out_valid;
    logic [W*NW-1:0] out_data;
    logic [NW-1:0]   out_ready;
    logic [15:0]     stall_count;

    scalar_io_handshake_bank u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .core_rden       (core_rden),
        .core_read_data  (core_read_data),
        .core_wren       (core_wren),
        .core_write_data (core_write_data),
        .io_ready        (io_ready),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .stall_count     (stall_count)
    );

    // Narrow stall counter instance for saturation.
    logic [NR-1:0]   s_rden;
    logic [W*NR-1:0] s_read_data;
    logic [NW-1:0]   s_wren;
    logic [W*NW-1:0] s_write_data;
    logic            s_io_ready;
    logic [NR-1:0]   s_in_valid;
    logic [W*NR-1:0] s_in_data;
    logic [NR-1:0]   s_in_ready;
    logic [NW-1:0]   s_out_valid;
    logic [W*NW-1:0] s_out_data;
    logic [NW-1:0]   s_out_ready;
    logic [3:0]      s_stall;

    scalar_io_handshake_bank #(.STALL_COUNT_WIDTH(4)) u_sat (
        .clock           (clock),
        .reset_n         (reset_n),
        .core_rden       (s_rden),
        .core_read_data  (s_read_data),
        .core_wren       (s_wren),
        .core_write_data (s_write_data),
        .io_ready        (s_io_ready),
        .in_valid        (s_in_valid),
        .in_data         (s_in_data),
        .in_ready        (s_in_ready),
        .out_valid       (s_out_valid),
        .out_data        (s_out_data),
        .out_ready       (s_out_ready),
        .stall_count     (s_stall)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0]  exp_rd [NR][$];
    logic [W-1:0]  exp_wr [NW][$];
    logic [NR-1:0] rd_pending = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare popped read words and drained write words against queues.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n !== 1'b1) begin
                rd_pending = '0;
            end else begin
                for (int i = 0; i < NR; i++) begin
                    if (rd_pending[i]) begin
                        if (exp_rd[i].size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL rd%0d_unexpected: got %0h expected none", i, core_read_data[i*W +: W]);
                        end else begin
                            check($sformatf("rd%0d_data", i), 64'(core_read_data[i*W +: W]), 64'(exp_rd[i].pop_front()));
                        end
                    end
                    rd_pending[i] = io_ready & core_rden[i];
                end
                for (int j = 0; j < NW; j++) begin
                    if (out_valid[j] & out_ready[j]) begin
                        if (exp_wr[j].size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL wr%0d_unexpected: got %0h expected none", j, out_data[j*W +: W]);
                        end else begin
                            check($sformatf("wr%0d_data", j), 64'(out_data[j*W +: W]), 64'(exp_wr[j].pop_front()));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        core_rden = '0; core_wren = '0; core_write_data = '0;
        in_valid = '0; in_data = '0; out_ready = '0;
        s_rden = '0; s_wren = '0; s_write_data = '0;
        s_in_valid = '0; s_in_data = '0; s_out_ready = '0;

        // Reset and idle
        tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_stall", 64'(stall_count), 64'h0);
        check("rst_rdata_zero", 64'(|core_read_data), 64'h0);
        check("rst_odata_zero", 64'(|out_data), 64'h0);
        reset_n = 1'b1;
        tick();
        check("rel_in_ready", 64'(in_ready), 64'hF);
        check("rel_io_ready", 64'(io_ready), 64'h1);

        // Empty read port blocks for three cycles, then fill and pop
        core_rden = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1 check("empty_blocked", 64'(io_ready), 64'h0);
            tick();
        end
        core_rden = '0;
        #1 check("stall_after_3", 64'(stall_count), 64'd3);
        in_valid = 4'b0001;
        in_data[0 +: W] = 36'h123456789;
        exp_rd[0].push_back(36'h123456789);
        tick();
        in_valid = '0;
        core_rden = 4'b0001;
        #1 check("rd0_io_ready", 64'(io_ready), 64'h1);
        tick();
        core_rden = '0;
        #1 check("rd0_direct", 64'(core_read_data[0 +: W]), 64'h123456789);
        check("stall_hold_3", 64'(stall_count), 64'd3);

        // Mixed access: port1 has data, port2 full with consumer stalled
        in_valid = 4'b0010;
        in_data[W +: W] = 36'h0_0000_B0B1;
        exp_rd[1].push_back(36'h0_0000_B0B1);
        core_wren = 4'b0100;
        core_write_data[2*W +: W] = 36'h2_2222_0001;
        exp_wr[2].push_back(36'h2_2222_0001);
        tick();
        in_valid = '0;
        core_write_data[2*W +: W] = 36'h2_2222_0002;
        exp_wr[2].push_back(36'h2_2222_0002);
        tick();
        core_wren = '0;
        #1 check("p2_full_valid", 64'(out_valid), 64'h4);
        check("p2_head", 64'(out_data[2*W +: W]), 64'h2_2222_0001);
        core_rden = 4'b0010;
        core_wren = 4'b0100;
        core_write_data[2*W +: W] = 36'h2_2222_0003;
        #1 check("mixed_blocked", 64'(io_ready), 64'h0);
        tick();
        #1 check("mixed_stall", 64'(stall_count), 64'd4);
        check("p1_no_pop", 64'(core_read_data[W +: W]), 64'h0);
        out_ready = 4'b0100;
        exp_wr[2].push_back(36'h2_2222_0003);
        #1 check("mixed_release", 64'(io_ready), 64'h1);
        tick();
        core_rden = '0; core_wren = '0; out_ready = '0;
        #1 check("p1_popped", 64'(core_read_data[W +: W]), 64'h0_0000_B0B1);
        check("p2_still_valid", 64'(out_valid[2]), 64'h1);
        check("p2_new_head", 64'(out_data[2*W +: W]), 64'h2_2222_0002);
        out_ready = 4'b0100;
        tick(); tick();
        out_ready = '0;
        #1 check("p2_drained", 64'(out_valid), 64'h0);

        // Write streaming on port3
        out_ready = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] v;
            v = 36'hA + 36'(k);
            core_wren = 4'b1000;
            core_write_data[3*W +: W] = v;
            exp_wr[3].push_back(v);
            #1 check("stream_io_ready", 64'(io_ready), 64'h1);
            tick();
            check("stream_head", 64'(out_data[3*W +: W]), 64'(v));
        end
        core_wren = '0;
        tick();
        out_ready = '0;
        #1 check("stream_empty", 64'(out_valid[3]), 64'h0);

        // Read backpressure on port2
        in_valid = 4'b0100;
        in_data[2*W +: W] = 36'hC_0000_0001;
        #1 check("bp_rdy1", 64'(in_ready[2]), 64'h1);
        exp_rd[2].push_back(36'hC_0000_0001);
        tick();
        in_data[2*W +: W] = 36'hC_0000_0002;
        #1 check("bp_rdy2", 64'(in_ready[2]), 64'h1);
        exp_rd[2].push_back(36'hC_0000_0002);
        tick();
        in_data[2*W +: W] = 36'hC_0000_0003;
        #1 check("bp_full", 64'(in_ready[2]), 64'h0);
        tick();
        core_rden = 4'b0100;
        #1 check("bp_full_pop", 64'(in_ready[2]), 64'h0);
        check("bp_pop_io_ready", 64'(io_ready), 64'h1);
        tick();
        #1 check("bp_reopen", 64'(in_ready[2]), 64'h1);
        exp_rd[2].push_back(36'hC_0000_0003);
        tick();
        in_data[2*W +: W] = 36'hC_0000_0004;
        #1 check("bp_stream", 64'(in_ready[2]), 64'h1);
        exp_rd[2].push_back(36'hC_0000_0004);
        tick();
        in_valid = '0;
        #1 check("bp_last_io_ready", 64'(io_ready), 64'h1);
        tick();
        core_rden = '0;
        #1 check("bp_idle_rdy", 64'(in_ready[2]), 64'h1);
        check("stall_final", 64'(stall_count), 64'd4);

        // Saturating stall counter (4-bit instance)
        s_rden = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 13) check("sat_14", 64'(s_stall), 64'd14);
            if (k == 14) check("sat_15", 64'(s_stall), 64'd15);
            if (k == 16) check("sat_nowrap", 64'(s_stall), 64'd15);
        end
        check("sat_held", 64'(s_stall), 64'd15);
        s_rden = '0;

        tick(); tick();
        for (int i = 0; i < NR; i++) check($sformatf("rd%0d_q_empty", i), 64'(exp_rd[i].size()), 64'h0);
        for (int j = 0; j < NW; j++) check($sformatf("wr%0d_q_empty", j), 64'(exp_wr[j].size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scalar_io_handshake_bank.md
Name: scalar_io_handshake_bank

Overview:
- Flow-controlled I/O port bank for the scalar core.
- Adds per-port FIFO buffering and valid/ready handshakes to the flat A/B-memory I/O read/write port vectors.
- Generates a single io_ready qualifier so the core annuls any instruction whose addressed ports cannot complete.
- Sits between the scalar datapath I/O lines and external accelerators/devices. One instance serves one memory (A or B).

Parameters:
WORD_WIDTH, 36, width of one I/O word
READ_PORT_COUNT, 4, number of input ports (1..8)
WRITE_PORT_COUNT, 4, number of output ports (1..8)
FIFO_DEPTH, 2, entries per port buffer; power of two, >=2
FIFO_ADDR_WIDTH, 1, log2(FIFO_DEPTH)
STALL_COUNT_WIDTH, 16, width of the saturating stall counter

Ports:
clock  in  1  sole clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
core_rden  in  READ_PORT_COUNT  per-port read request from core, this cycle
core_read_data  out  WORD_WIDTH*READ_PORT_COUNT  flat popped words, registered
core_wren  in  WRITE_PORT_COUNT  per-port write request from core
core_write_data  in  WORD_WIDTH*WRITE_PORT_COUNT  flat words to push
io_ready  out  1  combinational; 1 = all requested ports can complete now
in_valid  in  READ_PORT_COUNT  external word offered per read port
in_data  in  WORD_WIDTH*READ_PORT_COUNT  external words
in_ready  out  READ_PORT_COUNT  read port FIFO not full (registered)
out_valid  out  WRITE_PORT_COUNT  write port FIFO not empty (registered)
out_data  out  WORD_WIDTH*WRITE_PORT_COUNT  FIFO head words
out_ready  in  WRITE_PORT_COUNT  external consumer accepts head
stall_count  out  STALL_COUNT_WIDTH  saturating count of annulled access cycles

Behaviour:
- Reset (reset_n=0 at edge): all FIFOs empty; pointers 0; core_read_data=0; in_ready=0 while reset asserted, 1 on first cycle after release; out_valid=0; out_data=0; stall_count=0. Reset mid-transfer discards buffered words, no output glitch beyond these values.
- io_ready = AND over i of (!core_rden[i] | rd_fifo_nonempty[i]) AND over j of (!core_wren[j] | wr_fifo_notfull[j]). No request -> io_ready=1.
- Access is all-or-nothing: pops/pushes happen only when io_ready=1. io_ready=0 -> no FIFO changes from the core side; stall_count increments (saturates at all-ones, no wrap) if any rden/wren bit set.
- Read pop at edge ending cycle N -> word on core_read_data slice i in N+1 and held until next pop of that port. Unpopped slices hold their value.
- Write push at edge ending N -> visible at out_data in N+1 if FIFO was empty; out_valid rises in N+1.
- External side: transfer on in_valid&in_ready or out_valid&out_ready at rising edge; FIFO order preserved per port; ports fully independent.
- Simultaneous push and pop on the same FIFO: both occur, count unchanged. Allowed when full (external write-port drain plus core push, or core read-port pop plus external fill only if in_ready=1 — in_ready is registered from count, so a full read FIFO refuses external data even while being popped).
- Occupancy count range 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH; overflow/underflow impossible by construction. Driving in_valid while in_ready=0 is ignored, with no state change.
- Latency: external word -> core-visible (nonempty) one cycle after acceptance edge.
- Full throughput: one word per cycle per port in steady state with FIFO_DEPTH>=2.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles -> out_valid=0, in_ready=0, stall_count=0; cycle after release -> in_ready all 1, io_ready=1.
- Read port 0 empty, core_rden=0001 for 3 cycles -> io_ready=0 each cycle, stall_count=3, no pop. Then in_data[0]=36'h123456789 accepted -> next cycle io_ready=1; cycle after pop, core_read_data[0]=36'h123456789.
- Mixed access: rden=0010 (port1 has data) and wren=0100 (port2 full, out_ready=0) -> io_ready=0, port1 keeps its word. Release out_ready one cycle -> io_ready=1, pop and push both occur on that edge.
- Write streaming: core pushes 0xA,0xB,0xC,0xD to port3 on consecutive cycles with out_ready=1 -> out_data 0xA..0xD in order on consecutive cycles, io_ready never drops.
- Read backpressure: in_valid[2]=1 for 4 words, no core reads -> in_ready[2] falls after 2 accepted words; words 3-4 held externally; two pops -> order 1,2 then 3,4.
- Saturation: STALL_COUNT_WIDTH=4, blocked request for 20 cycles -> stall_count=15 and held.
